// File: rtl/wisc_pipe_pkg.sv
// Shared pipeline definitions for the WISC decode-side hazard logic:
// write-register select encodings, instruction field positions and the shadow entry type.
package wisc_pipe_pkg;

  localparam logic [1:0] WRSEL_RT = 2'b00;
  localparam logic [1:0] WRSEL_RD = 2'b01;
  localparam logic [1:0] WRSEL_RS = 2'b10;
  localparam logic [1:0] WRSEL_R7 = 2'b11;

  localparam int RS_MSB = 10;
  localparam int RS_LSB = 8;
  localparam int RT_MSB = 7;
  localparam int RT_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 2;

  localparam logic [2:0] RETURN_ADDR_REG = 3'h7;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       is_load;
  } shadow_entry_t;

endpackage

// File: rtl/wisc_dest_reg_decode.sv
// Maps WriteRegSel plus the instruction word to the 3-bit destination register.
// The forwarding unit instantiates this too, so both agree on destination mapping.
module wisc_dest_reg_decode
  import wisc_pipe_pkg::*;
#(
  parameter logic [2:0] RET_REG = wisc_pipe_pkg::RETURN_ADDR_REG
) (
  input  logic [15:0] instruction,
  input  logic [1:0]  write_reg_sel,
  output logic [2:0]  dest
);

  // Opcode and function bits never select a destination.
  logic unused_bits;
  assign unused_bits = ^{instruction[15:11], instruction[1:0]};

  always_comb begin
    dest = RET_REG;
    case (write_reg_sel)
      WRSEL_RT: dest = instruction[RT_MSB:RT_LSB];
      WRSEL_RD: dest = instruction[RD_MSB:RD_LSB];
      WRSEL_RS: dest = instruction[RS_MSB:RS_LSB];
      WRSEL_R7: dest = RET_REG;
      default:  dest = RET_REG;
    endcase
  end

endmodule

// File: rtl/load_use_hazard_unit.sv
// Decode-stage hazard tracker: shadows EX/MEM destinations and generates the
// IF/ID stall, ID/EX bubble and whole-pipe freeze controls.
module load_use_hazard_unit
  import wisc_pipe_pkg::*;
#(
  parameter logic [2:0] RETURN_ADDR_REG = wisc_pipe_pkg::RETURN_ADDR_REG,
  parameter int         CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          Instruction_IFID_out,
  input  logic                 Valid_IFID_out,
  input  logic                 ReadsRs_ID,
  input  logic                 ReadsRt_ID,
  input  logic                 RegWriteEnable_ID,
  input  logic [1:0]           WriteRegSel_ID,
  input  logic                 MemRead_ID,
  input  logic                 Flush_EX,
  input  logic                 MemBusy_MEM,
  output logic                 Stall_IFID,
  output logic                 Bubble_IDEX,
  output logic                 Freeze_Pipe,
  output logic [CNT_WIDTH-1:0] LoadUseStallCount
);

  shadow_entry_t ex_reg, ex_next;
  shadow_entry_t mem_reg, mem_next;
  shadow_entry_t id_entry;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [2:0] id_dest;
  logic       load_use;

  wisc_dest_reg_decode #(
    .RET_REG(RETURN_ADDR_REG)
  ) u_dest_decode (
    .instruction  (Instruction_IFID_out),
    .write_reg_sel(WriteRegSel_ID),
    .dest         (id_dest)
  );

  // The MEM entry is tracked for the forwarding side; no stall ever depends on it.
  logic unused_state;
  assign unused_state = ^{mem_reg, Instruction_IFID_out[15:11], Instruction_IFID_out[1:0]};

  assign id_entry.valid   = Valid_IFID_out & RegWriteEnable_ID;
  assign id_entry.dest    = id_dest;
  assign id_entry.is_load = MemRead_ID;

  // Only a load still in EX is out of reach of forwarding.
  assign load_use = ex_reg.valid & ex_reg.is_load & Valid_IFID_out &
                    ((ReadsRs_ID & (ex_reg.dest == Instruction_IFID_out[RS_MSB:RS_LSB])) |
                     (ReadsRt_ID & (ex_reg.dest == Instruction_IFID_out[RT_MSB:RT_LSB])));

  assign Freeze_Pipe       = ~rst & MemBusy_MEM;
  assign Stall_IFID        = ~rst & (MemBusy_MEM | (~Flush_EX & load_use));
  assign Bubble_IDEX       = ~rst & ~MemBusy_MEM & (Flush_EX | load_use);
  assign LoadUseStallCount = cnt_reg;

  always_comb begin
    ex_next  = ex_reg;
    mem_next = mem_reg;
    cnt_next = cnt_reg;
    if (!MemBusy_MEM) begin
      mem_next = ex_reg;
      if (Flush_EX || load_use) begin
        ex_next = '0;
        if (!Flush_EX && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else begin
        ex_next = id_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg  <= '0;
      mem_reg <= '0;
      cnt_reg <= '0;
    end else begin
      ex_reg  <= ex_next;
      mem_reg <= mem_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Scoreboard bench for load_use_hazard_unit: directed scenarios then random traffic,
// checked against a history-based reference model of what entered EX each cycle.
module tb_load_use_hazard_unit;

  localparam int CW = 4;

  typedef struct {
    bit stall;
    bit bubble;
    bit freeze;
    int count;
    int id;
  } exp_t;

  typedef struct {
    bit v;
    int dest;
    bit ld;
  } ins_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   instr;
  logic          vid, rs_rd, rt_rd, rwe, memrd, flush, busy;
  logic [1:0]    wsel;
  logic          stall, bubble, freeze;
  logic [CW-1:0] count;

  exp_t exp_q[$];
  ins_t hist[$];
  int   model_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc_id    = 0;
  bit   done      = 0;

  always #5 clk = ~clk;

  load_use_hazard_unit #(.CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Instruction_IFID_out(instr),
    .Valid_IFID_out      (vid),
    .ReadsRs_ID          (rs_rd),
    .ReadsRt_ID          (rt_rd),
    .RegWriteEnable_ID   (rwe),
    .WriteRegSel_ID      (wsel),
    .MemRead_ID          (memrd),
    .Flush_EX            (flush),
    .MemBusy_MEM         (busy),
    .Stall_IFID          (stall),
    .Bubble_IDEX         (bubble),
    .Freeze_Pipe         (freeze),
    .LoadUseStallCount   (count)
  );

  function automatic logic [15:0] mk(input int rs, input int rt, input int rd);
    logic [15:0] w;
    w = 16'h0;
    w[10:8] = 3'(rs);
    w[7:5]  = 3'(rt);
    w[4:2]  = 3'(rd);
    return w;
  endfunction

  function automatic int dest_of(input logic [15:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return int'(w[7:5]);
      2'd1:    return int'(w[4:2]);
      2'd2:    return int'(w[10:8]);
      default: return 7;
    endcase
  endfunction

  // One clock cycle: drive inputs, predict the outputs of this cycle, then advance the model.
  task automatic cyc(input logic [15:0] w, input bit v, input bit a, input bit b, input bit we,
                     input logic [1:0] sel, input bit ld, input bit fl, input bit bz, input bit r);
    exp_t e;
    bit   lu;
    ins_t prod;
    instr = w; vid = v; rs_rd = a; rt_rd = b; rwe = we; wsel = sel;
    memrd = ld; flush = fl; busy = bz; rst = r;
    lu = 1'b0;
    if (hist.size() > 0) begin
      prod = hist[$];
      lu = prod.v && prod.ld && v &&
           ((a && prod.dest == int'(w[10:8])) || (b && prod.dest == int'(w[7:5])));
    end
    e.count = model_cnt;
    e.id    = cyc_id;
    if (r) begin
      e.stall = 0; e.bubble = 0; e.freeze = 0;
    end else if (bz) begin
      e.stall = 1; e.bubble = 0; e.freeze = 1;
    end else if (fl) begin
      e.stall = 0; e.bubble = 1; e.freeze = 0;
    end else begin
      e.stall = lu; e.bubble = lu; e.freeze = 0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      hist.delete();
      model_cnt = 0;
    end else if (!bz) begin
      if (fl || lu) begin
        hist.push_back('{v: 0, dest: 0, ld: 0});
        if (lu && !fl && model_cnt < (1 << CW) - 1) model_cnt++;
      end else begin
        hist.push_back('{v: v && we, dest: dest_of(w, sel), ld: ld});
      end
      if (hist.size() > 4) void'(hist.pop_front());
    end
    cyc_id++;
    #1;
  endtask

  task automatic nop(input bit fl = 0, input bit bz = 0, input bit r = 0);
    cyc(16'h0, 0, 0, 0, 0, 2'd0, 0, fl, bz, r);
  endtask

  // Monitor: every cycle the DUT presents a set of outputs; compare with the queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (stall !== e.stall || bubble !== e.bubble || freeze !== e.freeze ||
          int'(count) != e.count || $isunknown(count)) begin
        n_fail++;
        $display("FAIL cycle%0d outputs: got stall=%0b bubble=%0b freeze=%0b count=%0d, expected stall=%0b bubble=%0b freeze=%0b count=%0d",
                 e.id, stall, bubble, freeze, count, e.stall, e.bubble, e.freeze, e.count);
      end else begin
        $display("cycle%0d ok: stall=%0b bubble=%0b freeze=%0b count=%0d",
                 e.id, stall, bubble, freeze, count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    nop(0, 0, 1);
    nop(0, 0, 1);
    // Load R2 then ADD reading Rs=R2: one stall, then ADD proceeds
    cyc(mk(0, 2, 0), 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
    cyc(mk(2, 1, 3), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    cyc(mk(2, 1, 3), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    // ALU producer Rd=R3 then SUB reading Rt=R3: no stall
    cyc(mk(1, 1, 3), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    cyc(mk(0, 3, 4), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    // Load R4, unrelated op, reader of R4: load already in MEM
    cyc(mk(0, 4, 0), 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
    cyc(mk(1, 1, 6), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    cyc(mk(4, 4, 6), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    // Load-use on R5 coinciding with a flush
    cyc(mk(0, 5, 0), 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
    cyc(mk(5, 0, 1), 1, 1, 0, 1, 2'd1, 0, 1, 0, 0);
    nop();
    // Load-use held under a 3-cycle memory freeze, then one stall
    cyc(mk(0, 6, 0), 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
    repeat (3) cyc(mk(6, 0, 1), 1, 1, 0, 1, 2'd1, 0, 0, 1, 0);
    cyc(mk(6, 0, 1), 1, 1, 0, 1, 2'd1, 0, 0, 0, 0);
    cyc(mk(6, 0, 1), 1, 1, 0, 1, 2'd1, 0, 0, 0, 0);
    // Return-address destination: load writing R7 then reader of R7
    cyc(mk(0, 0, 0), 1, 1, 0, 1, 2'd3, 1, 0, 0, 0);
    cyc(mk(0, 7, 0), 1, 0, 1, 1, 2'd1, 0, 0, 0, 0);
    cyc(mk(0, 7, 0), 1, 0, 1, 1, 2'd1, 0, 0, 0, 0);
    // 20 back-to-back load-use pairs drive the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) begin
      cyc(mk(3, 1, 0), 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
      cyc(mk(1, 2, 5), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
      cyc(mk(1, 2, 5), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    end
    // Reset asserted in the middle of a load-use stall
    cyc(mk(3, 1, 0), 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
    cyc(mk(1, 2, 5), 1, 1, 1, 1, 2'd1, 0, 0, 0, 1);
    cyc(mk(1, 2, 5), 1, 1, 1, 1, 2'd1, 0, 0, 0, 1);
    cyc(mk(1, 2, 5), 1, 1, 1, 1, 2'd1, 0, 0, 0, 0);
    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      cyc(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
          ($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    done = 1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
